lfsr_arbiter: RTL and testbench
===============================

LFSR_ARBITER -- requirements
Module: lfsr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the generator (2..16).
REQ-002 Parameter SEED, default 1212 (0x04BC), LFSR reset/fallback value; SHALL be nonzero.
REQ-003 clk_in  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_in  input  1  asynchronous, active-high reset.
REQ-005 req_in  input  NUM_REQ  per-requester request for one 16-bit random word.
REQ-006 seed_load_in  input  1  request to reload LFSR from seed_in.
REQ-007 seed_in  input  16  new LFSR state, sampled when seed_load_in is accepted.
REQ-008 gnt_out  output  NUM_REQ  registered one-hot grant, one-cycle pulse.
REQ-009 rand_valid_out  output  1  high exactly when gnt_out is nonzero.
REQ-010 rand_out  output  16  random word for the granted requester, valid with rand_valid_out.
REQ-011 rand_id_out  output  clog2(NUM_REQ)  index of granted requester, valid with rand_valid_out.
REQ-012 reseed_done_out  output  1  one-cycle pulse on the cycle the new seed is in effect.

Function
REQ-013 Internal 16-bit LFSR state q SHALL step as: n[0]=q[15], n[1]=q[0], n[2]=q[15]^q[1], n[k]=q[k-1] for k=3..14, n[15]=q[15]^q[14].
REQ-014 LFSR SHALL step only on a grant cycle, exactly once per grant; no free-running.
REQ-015 On a grant, rand_out SHALL carry the pre-step LFSR value; the next grant carries the stepped value.
REQ-016 FSM states: IDLE (arbitrate) and RESEED (one cycle, load seed); no other states.
REQ-017 IDLE: if seed_load_in=1, no grant is issued that cycle and the FSM goes to RESEED, with seed_in captured.
REQ-018 IDLE with seed_load_in=0: among eligible requesters, pick one round-robin and register its grant for the next cycle.
REQ-019 Eligible = req_in[i]=1 and gnt_out[i]=0 in the same cycle; a requester cannot be granted on two consecutive cycles.
REQ-020 Round-robin: pointer ptr (reset 0) is highest priority, then ptr+1 .. wrapping mod NUM_REQ; after a grant to i, ptr becomes (i+1) mod NUM_REQ.
REQ-021 Grant latency: req_in sampled high at edge t yields gnt_out at edge t+1 (one cycle).
REQ-022 Back-to-back grants to different requesters on consecutive cycles SHALL be supported (throughput 1 word/cycle).
REQ-023 RESEED: LFSR loads the captured seed, or SEED if the captured value is 0x0000; reseed_done_out pulses; FSM returns to IDLE next cycle.
REQ-024 Requests held during RESEED are not lost; they arbitrate in the following IDLE cycle.
REQ-025 seed_load_in while in RESEED SHALL be ignored.
REQ-026 gnt_out, rand_valid_out, rand_id_out and reseed_done_out SHALL be registered with no combinational path from inputs.
REQ-027 rand_out and rand_id_out hold their last values when rand_valid_out=0.

Reset
REQ-028 While rst_in=1, regardless of clock: q=SEED, ptr=0, FSM=IDLE, gnt_out=0, rand_valid_out=0, rand_out=0, rand_id_out=0, reseed_done_out=0.
REQ-029 Reset mid-operation SHALL discard any pending grant or reseed; the first post-reset grant SHALL return SEED.

Verification
REQ-030 After reset, req_in=0001 for one cycle -> next cycle gnt_out=0001, rand_id_out=0, rand_out=0x04BC; a second single request returns 0x0978, then 0x12F0.
REQ-031 req_in=1111 held continuously -> grants rotate 0,1,2,3,0 on consecutive cycles, each one-hot, with rand_out following the LFSR sequence 0x04BC, 0x0978, 0x12F0, ...
REQ-032 Only req_in[2] held high -> gnt_out[2] pulses every other cycle, never on two consecutive cycles.
REQ-033 seed_load_in=1 with seed_in=0xACE1 and req_in=0001 in the same cycle -> no grant that cycle, reseed_done_out pulses next cycle, then the grant returns rand_out=0xACE1.
REQ-034 seed_load_in with seed_in=0x0000 -> next grant returns 0x04BC (SEED fallback).
REQ-035 rst_in asserted asynchronously between clock edges during a grant stream -> all outputs 0 immediately; after release, the first grant returns 0x04BC to requester 0 priority.

Source files
------------

// File: rtl/lfsr_arbiter.sv
// Round-robin arbiter handing out 16-bit LFSR words, one per grant, with
// an optional two-cycle reseed path (capture in IDLE, load in RESEED).
module lfsr_arbiter #(
    parameter int          NUM_REQ = 4,
    parameter logic [15:0] SEED    = 16'h04BC
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic [NUM_REQ-1:0]         req_in,
    input  logic                       seed_load_in,
    input  logic [15:0]                seed_in,
    output logic [NUM_REQ-1:0]         gnt_out,
    output logic                       rand_valid_out,
    output logic [15:0]                rand_out,
    output logic [$clog2(NUM_REQ)-1:0] rand_id_out,
    output logic                       reseed_done_out
);

    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic {
        IDLE   = 1'b0,
        RESEED = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       lfsr_q;
    logic [15:0]       seed_q;
    logic [ID_W-1:0]   ptr_q;
    logic [ID_W-1:0]   ptr_next;
    logic [ID_W-1:0]   pick_idx;
    logic [ID_W-1:0]   cand;
    logic              pick_valid;
    logic              grant_en;
    logic              seed_capture;
    logic [NUM_REQ-1:0] eligible;

    function automatic logic [15:0] lfsr_step(input logic [15:0] q);
        logic [15:0] n;
        n        = {q[14:0], q[15]};
        n[2]     = q[15] ^ q[1];
        n[15]    = q[15] ^ q[14];
        return n;
    endfunction

    // A requester granted this cycle sits out the next arbitration.
    assign eligible = req_in & ~gnt_out;

    // Search from ptr upward, wrapping; first eligible requester wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise paths that skip an assignment infer a latch.
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = ID_W'((int'(ptr_q) + off) % NUM_REQ);
            if (!pick_valid && eligible[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign ptr_next = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + ID_W'(1);

    always_comb begin
        state_d      = state_q;
        grant_en     = 1'b0;
        seed_capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (seed_load_in) begin
                    state_d      = RESEED;
                    seed_capture = 1'b1;
                end else if (pick_valid) begin
                    grant_en = 1'b1;
                end
            end
            RESEED: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            // NOTE: seed_q is reset too, so a reset mid-reseed leaves no stale
            // capture that could leak into a later load.
            lfsr_q          <= SEED;
            seed_q          <= '0;
            ptr_q           <= '0;
            gnt_out         <= '0;
            rand_valid_out  <= 1'b0;
            rand_out        <= '0;
            rand_id_out     <= '0;
            reseed_done_out <= 1'b0;
        end else begin
            gnt_out         <= '0;
            rand_valid_out  <= 1'b0;
            reseed_done_out <= 1'b0;

            if (seed_capture) begin
                seed_q <= seed_in;
            end

            if (grant_en) begin
                gnt_out        <= NUM_REQ'(1) << pick_idx;
                rand_valid_out <= 1'b1;
                rand_out       <= lfsr_q;
                rand_id_out    <= pick_idx;
                lfsr_q         <= lfsr_step(lfsr_q);
                ptr_q          <= ptr_next;
            end

            // An all-zero state would lock the LFSR, so fall back to SEED.
            if (state_q == RESEED) begin
                lfsr_q          <= (seed_q == 16'h0000) ? SEED : seed_q;
                reseed_done_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lfsr_arbiter.sv
// Directed bench for lfsr_arbiter: grant rotation, LFSR words, reseed and
// asynchronous reset, all against hand-computed values.
module tb_lfsr_arbiter;

    logic        clk_in;
    logic        rst_in;
    logic [3:0]  req_in;
    logic        seed_load_in;
    logic [15:0] seed_in;
    logic [3:0]  gnt_out;
    logic        rand_valid_out;
    logic [15:0] rand_out;
    logic [1:0]  rand_id_out;
    logic        reseed_done_out;

    int total;
    int bad;

    lfsr_arbiter #(.NUM_REQ(4), .SEED(16'h04BC)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .req_in          (req_in),
        .seed_load_in    (seed_load_in),
        .seed_in         (seed_in),
        .gnt_out         (gnt_out),
        .rand_valid_out  (rand_valid_out),
        .rand_out        (rand_out),
        .rand_id_out     (rand_id_out),
        .reseed_done_out (reseed_done_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_grant(input string tag, input logic [3:0] g, input logic [1:0] id,
                               input logic [15:0] r);
        check({tag, "_gnt"}, 32'(gnt_out), 32'(g));
        check({tag, "_vld"}, 32'(rand_valid_out), 32'(g != 4'b0));
        check({tag, "_id"}, 32'(rand_id_out), 32'(id));
        check({tag, "_rand"}, 32'(rand_out), 32'(r));
    endtask

    // Expected rotation and LFSR words for req_in=1111 straight after reset.
    logic [3:0]  rot_gnt  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0]  rot_id   [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [15:0] rot_rand [5] = '{16'h04BC, 16'h0978, 16'h12F0, 16'h25E0, 16'h4BC0};

    initial begin
        total        = 0;
        bad          = 0;
        rst_in       = 1'b1;
        req_in       = '0;
        seed_load_in = 1'b0;
        seed_in      = '0;

        #2;
        check_grant("reset", 4'b0000, 2'd0, 16'h0000);
        check("reset_done", 32'(reseed_done_out), 32'd0);
        tick();
        tick();
        rst_in = 1'b0;

        // Isolated single requests walk the LFSR sequence.
        req_in = 4'b0001; tick();
        check_grant("single0", 4'b0001, 2'd0, 16'h04BC);
        req_in = 4'b0000; tick();
        check_grant("hold0", 4'b0000, 2'd0, 16'h04BC);
        req_in = 4'b0001; tick();
        check_grant("single1", 4'b0001, 2'd0, 16'h0978);
        req_in = 4'b0000; tick();
        req_in = 4'b0001; tick();
        check_grant("single2", 4'b0001, 2'd0, 16'h12F0);
        req_in = 4'b0000; tick();

        // Asynchronous reset clears held outputs between edges.
        #4 rst_in = 1'b1;
        #1;
        check("async_rst_rand", 32'(rand_out), 32'd0);
        rst_in = 1'b0;

        // All four requesting: one-hot rotation, one word per cycle.
        req_in = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_grant($sformatf("rot%0d", i), rot_gnt[i], rot_id[i], rot_rand[i]);
        end

        // A lone requester is granted only every other cycle.
        req_in = 4'b0100; tick();
        check_grant("solo_a", 4'b0100, 2'd2, 16'h9780);
        tick();
        check_grant("solo_gap", 4'b0000, 2'd2, 16'h9780);
        tick();
        check_grant("solo_b", 4'b0100, 2'd2, 16'hAF05);
        tick();
        check("solo_gap2", 32'(gnt_out), 32'd0);

        // Reseed preempts the request; a second load during RESEED is ignored.
        req_in = 4'b0001; seed_load_in = 1'b1; seed_in = 16'hACE1; tick();
        check("rs_nogrant", 32'(gnt_out), 32'd0);
        check("rs_done_early", 32'(reseed_done_out), 32'd0);
        seed_in = 16'h1234; tick();
        check("rs_done", 32'(reseed_done_out), 32'd1);
        check("rs_gnt_in_reseed", 32'(gnt_out), 32'd0);
        seed_load_in = 1'b0; tick();
        check_grant("rs_grant", 4'b0001, 2'd0, 16'hACE1);
        check("rs_done_clear", 32'(reseed_done_out), 32'd0);

        // Zero seed falls back to SEED.
        req_in = 4'b0000; seed_load_in = 1'b1; seed_in = 16'h0000; tick();
        check("zs_done_early", 32'(reseed_done_out), 32'd0);
        seed_load_in = 1'b0; req_in = 4'b0001; tick();
        check("zs_done", 32'(reseed_done_out), 32'd1);
        tick();
        check_grant("zs_grant", 4'b0001, 2'd0, 16'h04BC);

        // Reset in the middle of a grant stream.
        req_in = 4'b1111; tick();
        check_grant("str_a", 4'b0010, 2'd1, 16'h0978);
        tick();
        check_grant("str_b", 4'b0100, 2'd2, 16'h12F0);
        #3 rst_in = 1'b1;
        #1;
        check_grant("mid_rst", 4'b0000, 2'd0, 16'h0000);
        check("mid_rst_done", 32'(reseed_done_out), 32'd0);
        rst_in = 1'b0;
        tick();
        check_grant("post_rst", 4'b0001, 2'd0, 16'h04BC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
